// File: rtl/key_debounce.sv
// key_debounce: per-key 2-flop synchronizer, stable-count debouncer and
// press / release / long-press pulse generator. Channels are independent.
module key_debounce #(
   parameter int unsigned NUM_KEYS        = 3,
   parameter logic [31:0] DEBOUNCE_CYCLES = 32'd500000,
   parameter logic [31:0] HOLD_CYCLES     = 32'd50000000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_KEYS-1:0] key_n,
   output logic [NUM_KEYS-1:0] key_level,
   output logic [NUM_KEYS-1:0] key_press,
   output logic [NUM_KEYS-1:0] key_release,
   output logic [NUM_KEYS-1:0] key_long
);

   typedef enum logic [1:0] {
      ST_RELEASED = 2'd0,
      ST_PRESSED  = 2'd1,
      ST_HELD     = 2'd2
   } state_t;

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
      logic        sync1;
      logic        sync2;
      state_t      state_q;
      state_t      state_d;
      logic [31:0] db_cnt_q;
      logic [31:0] db_cnt_d;
      logic [31:0] hold_cnt_q;
      logic [31:0] hold_cnt_d;
      logic [31:0] db_next;
      logic [31:0] hold_next;
      logic        press_q;
      logic        press_d;
      logic        release_q;
      logic        release_d;
      logic        long_q;
      logic        long_d;
      logic        level;

      // State register: synchronizer, FSM state, counters and registered pulses
      always_ff @(posedge clk) begin
         if (reset) begin
            sync1      <= 1'b1;
            sync2      <= 1'b1;
            state_q    <= ST_RELEASED;
            db_cnt_q   <= '0;
            hold_cnt_q <= '0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            long_q     <= 1'b0;
         end else begin
            sync1      <= key_n[i];
            sync2      <= sync1;
            state_q    <= state_d;
            db_cnt_q   <= db_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            press_q    <= press_d;
            release_q  <= release_d;
            long_q     <= long_d;
         end
      end

      // Next-state logic: debounce toward the opposite level, age the press
      always_comb begin
         state_d    = state_q;
         db_cnt_d   = db_cnt_q;
         hold_cnt_d = hold_cnt_q;
         press_d    = 1'b0;
         release_d  = 1'b0;
         long_d     = 1'b0;
         db_next    = db_cnt_q + 32'd1;
         hold_next  = hold_cnt_q + 32'd1;

         case (state_q)
            ST_RELEASED: begin
               if (!sync2) begin
                  if (db_next == DEBOUNCE_CYCLES) begin
                     state_d    = ST_PRESSED;
                     press_d    = 1'b1;
                     db_cnt_d   = '0;
                     hold_cnt_d = '0;
                  end else begin
                     db_cnt_d = db_next;
                  end
               end else begin
                  db_cnt_d = '0;
               end
            end

            ST_PRESSED, ST_HELD: begin
               if (state_q == ST_PRESSED) begin
                  if (hold_next == HOLD_CYCLES) begin
                     state_d = ST_HELD;
                     long_d  = 1'b1;
                  end else begin
                     hold_cnt_d = hold_next;
                  end
               end
               // Release is evaluated last so it overrides a coincident hold expiry.
               if (sync2) begin
                  if (db_next == DEBOUNCE_CYCLES) begin
                     state_d    = ST_RELEASED;
                     release_d  = 1'b1;
                     long_d     = 1'b0;
                     db_cnt_d   = '0;
                     hold_cnt_d = '0;
                  end else begin
                     db_cnt_d = db_next;
                  end
               end else begin
                  db_cnt_d = '0;
               end
            end

            default: begin
               state_d    = ST_RELEASED;
               db_cnt_d   = '0;
               hold_cnt_d = '0;
            end
         endcase
      end

      // Output logic: debounced level follows the FSM state
      always_comb begin
         level = (state_q != ST_RELEASED);
      end

      assign key_level[i]   = level;
      assign key_press[i]   = press_q;
      assign key_release[i] = release_q;
      assign key_long[i]    = long_q;
   end

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: table-driven and hand-written sequences plus randomized
// stimulus, every cycle compared against a run-length reference model.
module tb_key_debounce;

   localparam int DEB  = 4;
   localparam int HOLD = 10;

   logic       clk;
   logic       reset;
   logic [2:0] key_n;
   logic [2:0] key_level;
   logic [2:0] key_press;
   logic [2:0] key_release;
   logic [2:0] key_long;

   int checks = 0;
   int errors = 0;

   key_debounce #(
      .NUM_KEYS        (3),
      .DEBOUNCE_CYCLES (32'd4),
      .HOLD_CYCLES     (32'd10)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .key_n       (key_n),
      .key_level   (key_level),
      .key_press   (key_press),
      .key_release (key_release),
      .key_long    (key_long)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: two-cycle input delay, then a level flips once the
   // delayed input has disagreed with it for DEB consecutive edges.
   logic [2:0] m_s1    = '1;
   logic [2:0] m_s2    = '1;
   logic [2:0] m_lvl   = '0;
   logic [2:0] m_ldone = '0;
   int         m_run [3];
   int         m_age [3];
   logic [2:0] m_press   = '0;
   logic [2:0] m_release = '0;
   logic [2:0] m_long    = '0;

   task automatic model_edge();
      logic want;
      m_press   = '0;
      m_release = '0;
      m_long    = '0;
      for (int i = 0; i < 3; i++) begin
         if (reset) begin
            m_s1[i] = 1'b1; m_s2[i] = 1'b1; m_lvl[i] = 1'b0;
            m_run[i] = 0; m_age[i] = 0; m_ldone[i] = 1'b0;
         end else begin
            want = ~m_s2[i];
            if (want != m_lvl[i]) m_run[i]++;
            else m_run[i] = 0;
            if (m_run[i] == DEB) begin
               m_lvl[i] = want;
               m_run[i] = 0;
               if (want) begin
                  m_press[i] = 1'b1; m_age[i] = 0; m_ldone[i] = 1'b0;
               end else begin
                  m_release[i] = 1'b1;
               end
            end else if (m_lvl[i] && !m_ldone[i]) begin
               m_age[i]++;
               if (m_age[i] == HOLD) begin
                  m_long[i] = 1'b1; m_ldone[i] = 1'b1;
               end
            end
            m_s2[i] = m_s1[i];
            m_s1[i] = key_n[i];
         end
      end
   endtask

   task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0t got %b expected %b", name, $time, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, act, exp);
      end
   endtask

   // One clock edge: advance the model, then compare all outputs after the edge.
   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      chk("model_level",   key_level,   m_lvl);
      chk("model_press",   key_press,   m_press);
      chk("model_release", key_release, m_release);
      chk("model_long",    key_long,    m_long);
   endtask

   typedef struct {
      logic       rst;
      logic [2:0] kn;
      logic [2:0] lvl;
      logic [2:0] prs;
      logic [2:0] rel;
      logic [2:0] lng;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic rst, input logic [2:0] kn, input logic [2:0] lvl,
                               input logic [2:0] prs, input logic [2:0] rel, input logic [2:0] lng);
      vec_t v;
      v.rst = rst; v.kn = kn; v.lvl = lvl; v.prs = prs; v.rel = rel; v.lng = lng;
      vecs.push_back(v);
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  pat;
      logic [2:0]  kv;
      int unsigned dur [3];
      int np, nl, nr, nl0, pe, le, re;

      reset = 1'b1;
      key_n = 3'b111;

      // ---------------- vector table ----------------
      for (int j = 0; j < 3; j++)  add(1'b1, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000);
      for (int j = 0; j < 20; j++) add(1'b0, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000);
      // clean press / release of key 1
      for (int j = 0; j < 8; j++)
         add(1'b0, 3'b101, (j >= 5) ? 3'b010 : 3'b000, (j == 5) ? 3'b010 : 3'b000, 3'b000, 3'b000);
      for (int j = 0; j < 6; j++)
         add(1'b0, 3'b111, (j < 5) ? 3'b010 : 3'b000, 3'b000, (j == 5) ? 3'b010 : 3'b000, 3'b000);
      for (int j = 0; j < 4; j++) add(1'b0, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000);
      // bounce on key 0: 0,0,0,1,0,0,0,1 then steady low
      pat = 8'b1000_1000;
      for (int j = 0; j < 8; j++)
         add(1'b0, {2'b11, pat[j]}, 3'b000, 3'b000, 3'b000, 3'b000);
      for (int j = 0; j < 8; j++)
         add(1'b0, 3'b110, (j >= 5) ? 3'b001 : 3'b000, (j == 5) ? 3'b001 : 3'b000, 3'b000, 3'b000);
      for (int j = 0; j < 6; j++)
         add(1'b0, 3'b111, (j < 5) ? 3'b001 : 3'b000, 3'b000, (j == 5) ? 3'b001 : 3'b000, 3'b000);
      for (int j = 0; j < 4; j++) add(1'b0, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000);

      foreach (vecs[n]) begin
         reset = vecs[n].rst;
         key_n = vecs[n].kn;
         step();
         chk($sformatf("vec%0d_level", n),   key_level,   vecs[n].lvl);
         chk($sformatf("vec%0d_press", n),   key_press,   vecs[n].prs);
         chk($sformatf("vec%0d_release", n), key_release, vecs[n].rel);
         chk($sformatf("vec%0d_long", n),    key_long,    vecs[n].lng);
      end

      // ---------------- long press on key 2 ----------------
      key_n = 3'b011; np = 0; nl = 0; pe = -1; le = -1;
      for (int t = 0; t < 30; t++) begin
         step();
         if (key_press[2]) begin np++; pe = t; end
         if (key_long[2])  begin nl++; le = t; end
      end
      chk_int("long_press_count", np, 1);
      chk_int("long_press_edge",  pe, 5);
      chk_int("long_long_count",  nl, 1);
      chk_int("long_long_edge",   le, 15);
      key_n = 3'b111; nr = 0; re = -1;
      for (int t = 0; t < 10; t++) begin
         step();
         if (key_release[2]) begin nr++; re = t; end
      end
      chk_int("long_release_count", nr, 1);
      chk_int("long_release_edge",  re, 5);

      // ---------------- simultaneous keys / release-hold collision ----------------
      nl0 = 0;
      for (int t = 0; t < 36; t++) begin
         key_n = (t < 10) ? 3'b010 : ((t < 25) ? 3'b011 : 3'b111);
         step();
         if (key_long[0]) nl0++;
         if (t == 5)  chk("sim_press", key_press, 3'b101);
         if (t == 15) begin
            chk("coll_release", key_release, 3'b001);
            chk("coll_long",    key_long,    3'b100);
            chk("coll_level",   key_level,   3'b100);
         end
         if (t == 30) chk("sim_release2", key_release, 3'b100);
      end
      chk_int("coll_long0_count", nl0, 0);

      // ---------------- reset mid-press ----------------
      key_n = 3'b101;
      for (int t = 0; t < 8; t++) step();
      chk("rstmid_pre_level", key_level, 3'b010);
      reset = 1'b1;
      step();
      chk("rstmid_level",   key_level,   3'b000);
      chk("rstmid_release", key_release, 3'b000);
      chk("rstmid_press",   key_press,   3'b000);
      reset = 1'b0; np = 0; nr = 0; pe = -1;
      for (int t = 1; t <= 10; t++) begin
         step();
         if (key_press[1])   begin np++; pe = t; end
         if (key_release[1]) nr++;
      end
      chk_int("rstmid_repress_count", np, 1);
      chk_int("rstmid_repress_edge",  pe, 6);
      chk_int("rstmid_no_release",    nr, 0);
      key_n = 3'b111;
      for (int t = 0; t < 10; t++) step();

      // ---------------- randomized stimulus against the model ----------------
      kv = 3'b111;
      for (int i = 0; i < 3; i++) dur[i] = 0;
      for (int t = 0; t < 3000; t++) begin
         for (int i = 0; i < 3; i++) begin
            if (dur[i] == 0) begin
               kv[i]  = 1'($urandom_range(0, 1));
               dur[i] = $urandom_range(1, 25);
            end
            dur[i]--;
         end
         key_n = kv;
         reset = ($urandom_range(0, 399) == 0);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
